// File: rtl/cby_param_shadow.sv
// Y-direction connection block: vertical track pass-through plus NUM_IPIN tree muxes.
// The mux selects come from a shadow register loaded from a serial chain by a commit handshake.
module cby_param_shadow #(
   parameter int CHAN_WIDTH = 30,
   parameter int NUM_IPIN   = 4,
   parameter int MUX_SIZE   = 12,
   parameter int SEL_BITS   = 4
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic                  ccff_head,
   input  logic                  ccff_shift_en,
   input  logic                  ccff_commit,
   output logic                  ccff_tail,
   output logic                  cfg_done,
   output logic                  cfg_err,
   input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
   input  logic [CHAN_WIDTH-1:0] chany_top_in,
   output logic [CHAN_WIDTH-1:0] chany_bottom_out,
   output logic [CHAN_WIDTH-1:0] chany_top_out,
   output logic [NUM_IPIN-1:0]   ipin_out
);

   localparam int CFG_BITS = NUM_IPIN * SEL_BITS;
   localparam int CNT_W    = $clog2(CFG_BITS + 1);
   localparam int STRIDE   = CHAN_WIDTH / (MUX_SIZE / 2);
   localparam int MUX_PAD  = 2 ** SEL_BITS;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FILLED = 2'd2
   } state_t;

   state_t                 state_r;
   logic [CFG_BITS-1:0]    chain_r;
   logic [CFG_BITS-1:0]    shadow_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   cfg_done_r;
   logic                   cfg_err_r;
   logic                   commit_legal_s;
   logic [NUM_IPIN-1:0]    ipin_s;
   logic [NUM_IPIN-1:0][MUX_PAD-1:0] mux_in_s;

   assign chany_bottom_out = chany_top_in;
   assign chany_top_out    = chany_bottom_in;
   assign ccff_tail        = chain_r[CFG_BITS-1];
   assign cfg_done         = cfg_done_r;
   assign cfg_err          = cfg_err_r;
   assign ipin_out         = ipin_s;

   // Commit is accepted only from a full chain with no concurrent shift.
   always_comb begin
      commit_legal_s = 1'b0;
      if (ccff_commit && !ccff_shift_en && (state_r == ST_FILLED)) begin
         commit_legal_s = 1'b1;
      end else begin
         commit_legal_s = 1'b0;
      end
   end

   // Config chain, bit counter, load FSM and shadow register.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_r    <= ST_IDLE;
         chain_r    <= {CFG_BITS{1'b0}};
         shadow_r   <= {CFG_BITS{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         cfg_done_r <= 1'b0;
         cfg_err_r  <= 1'b0;
      end else begin
         if (ccff_shift_en) begin
            chain_r <= {chain_r[CFG_BITS-2:0], ccff_head};
            if (cnt_r != CNT_FULL) begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end
         if (ccff_commit && !commit_legal_s) begin
            cfg_err_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (ccff_shift_en) begin
                  state_r <= (cnt_r == CNT_LAST) ? ST_FILLED : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (ccff_shift_en && (cnt_r == CNT_LAST)) begin
                  state_r <= ST_FILLED;
               end
            end
            ST_FILLED: begin
               if (commit_legal_s) begin
                  shadow_r   <= chain_r;
                  cfg_done_r <= 1'b1;
                  cnt_r      <= {CNT_W{1'b0}};
                  state_r    <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Mux inputs padded to a power of two; selects at or beyond MUX_SIZE read a constant zero.
   for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
      for (genvar gk = 0; gk < MUX_PAD; gk++) begin : g_in
         if (gk < MUX_SIZE) begin : g_track
            localparam int TRK = (gi + (gk / 2) * STRIDE) % CHAN_WIDTH;
            if ((gk % 2) == 0) begin : g_bot
               assign mux_in_s[gi][gk] = chany_bottom_in[TRK];
            end else begin : g_top
               assign mux_in_s[gi][gk] = chany_top_in[TRK];
            end
         end else begin : g_pad
            assign mux_in_s[gi][gk] = 1'b0;
         end
      end
   end

   // Grid pin muxes, held at zero until a configuration has been committed.
   always_comb begin
      ipin_s = {NUM_IPIN{1'b0}};
      for (int i = 0; i < NUM_IPIN; i++) begin
         if (cfg_done_r) begin
            ipin_s[i] = mux_in_s[i][shadow_r[i*SEL_BITS +: SEL_BITS]];
         end else begin
            ipin_s[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Directed bench for cby_param_shadow: reset, loads, illegal commits, reprogramming, reset mid-shift.
module tb_cby_param_shadow;

   logic        prog_clk = 1'b0;
   logic        prog_reset;
   logic        ccff_head;
   logic        ccff_shift_en;
   logic        ccff_commit;
   logic        ccff_tail;
   logic        cfg_done;
   logic        cfg_err;
   logic [29:0] chany_bottom_in;
   logic [29:0] chany_top_in;
   logic [29:0] chany_bottom_out;
   logic [29:0] chany_top_out;
   logic [3:0]  ipin_out;

   int n_vec = 0;
   int n_err = 0;

   cby_param_shadow dut (
      .prog_clk         (prog_clk),
      .prog_reset       (prog_reset),
      .ccff_head        (ccff_head),
      .ccff_shift_en    (ccff_shift_en),
      .ccff_commit      (ccff_commit),
      .ccff_tail        (ccff_tail),
      .cfg_done         (cfg_done),
      .cfg_err          (cfg_err),
      .chany_bottom_in  (chany_bottom_in),
      .chany_top_in     (chany_top_in),
      .chany_bottom_out (chany_bottom_out),
      .chany_top_out    (chany_top_out),
      .ipin_out         (ipin_out)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic shift_bits(input logic [15:0] w, input int hi, input int lo);
      for (int b = hi; b >= lo; b--) begin
         ccff_head     = w[b];
         ccff_shift_en = 1'b1;
         tick();
      end
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
   endtask

   task automatic do_commit();
      ccff_commit = 1'b1;
      tick();
      ccff_commit = 1'b0;
   endtask

   task automatic apply_reset();
      prog_reset = 1'b1;
      tick();
      prog_reset = 1'b0;
   endtask

   task automatic test_reset();
      prog_reset      = 1'b1;
      chany_bottom_in = 30'h2AAAAAAA;
      chany_top_in    = 30'h15555555;
      tick();
      tick();
      n_vec++; if (chany_top_out !== 30'h2AAAAAAA) begin n_err++; $display("FAIL reset_thru_top: got %h want %h", chany_top_out, 30'h2AAAAAAA); end
      n_vec++; if (chany_bottom_out !== 30'h15555555) begin n_err++; $display("FAIL reset_thru_bot: got %h want %h", chany_bottom_out, 30'h15555555); end
      prog_reset = 1'b0;
      tick();
      tick();
      n_vec++; if (ipin_out !== 4'b0000) begin n_err++; $display("FAIL reset_ipin: got %b want 0000", ipin_out); end
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", cfg_done); end
      n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", cfg_err); end
      n_vec++; if (ccff_tail !== 1'b0) begin n_err++; $display("FAIL reset_tail: got %b want 0", ccff_tail); end
      n_vec++; if (chany_top_out !== 30'h2AAAAAAA) begin n_err++; $display("FAIL idle_thru_top: got %h want %h", chany_top_out, 30'h2AAAAAAA); end
   endtask

   task automatic test_basic_load();
      chany_top_in    = 30'h0000_0020;
      chany_bottom_in = 30'h0;
      shift_bits(16'h0123, 15, 0);
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL load_done_pre: got %b want 0", cfg_done); end
      do_commit();
      n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b want 1", cfg_done); end
      n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL load_err: got %b want 0", cfg_err); end
      n_vec++; if (ipin_out !== 4'b0001) begin n_err++; $display("FAIL load_top5: got %b want 0001", ipin_out); end
      chany_top_in    = 30'h0;
      chany_bottom_in = 30'h0000_0040;
      #1;
      n_vec++; if (ipin_out !== 4'b0010) begin n_err++; $display("FAIL load_bot6: got %b want 0010", ipin_out); end
      chany_top_in    = 30'h0000_0004;
      chany_bottom_in = 30'h0;
      #1;
      n_vec++; if (ipin_out !== 4'b0100) begin n_err++; $display("FAIL load_top2: got %b want 0100", ipin_out); end
      chany_top_in    = 30'h0;
      chany_bottom_in = 30'h0000_0008;
      #1;
      n_vec++; if (ipin_out !== 4'b1000) begin n_err++; $display("FAIL load_bot3: got %b want 1000", ipin_out); end
   endtask

   task automatic test_illegal_commit();
      apply_reset();
      chany_top_in    = 30'h0000_0020;
      chany_bottom_in = 30'h0;
      shift_bits(16'h0123, 15, 6);
      do_commit();
      n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL early_err: got %b want 1", cfg_err); end
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL early_done: got %b want 0", cfg_done); end
      n_vec++; if (ipin_out !== 4'b0000) begin n_err++; $display("FAIL early_ipin: got %b want 0000", ipin_out); end
      shift_bits(16'h0123, 5, 0);
      do_commit();
      n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL late_done: got %b want 1", cfg_done); end
      n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL late_err_sticky: got %b want 1", cfg_err); end
      n_vec++; if (ipin_out !== 4'b0001) begin n_err++; $display("FAIL late_ipin: got %b want 0001", ipin_out); end
   endtask

   task automatic test_commit_with_shift();
      apply_reset();
      chany_top_in    = 30'h0000_0020;
      chany_bottom_in = 30'h0;
      shift_bits(16'h0123, 15, 1);
      ccff_head     = 1'b1;
      ccff_shift_en = 1'b1;
      ccff_commit   = 1'b1;
      tick();
      ccff_shift_en = 1'b0;
      ccff_commit   = 1'b0;
      ccff_head     = 1'b0;
      n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL both_err: got %b want 1", cfg_err); end
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL both_done: got %b want 0", cfg_done); end
      do_commit();
      n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL both_then_done: got %b want 1", cfg_done); end
      n_vec++; if (ipin_out !== 4'b0001) begin n_err++; $display("FAIL both_then_ipin: got %b want 0001", ipin_out); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] old_w = 16'h0123;
      logic [15:0] new_w = 16'h7A5D;
      chany_top_in    = 30'h0004_0820;
      chany_bottom_in = 30'h0800_0040;
      #1;
      n_vec++; if (ipin_out !== 4'b0011) begin n_err++; $display("FAIL reprog_before: got %b want 0011", ipin_out); end
      for (int b = 15; b >= 0; b--) begin
         n_vec++; if (ccff_tail !== old_w[b]) begin n_err++; $display("FAIL reprog_tail%0d: got %b want %b", b, ccff_tail, old_w[b]); end
         n_vec++; if (ipin_out !== 4'b0011) begin n_err++; $display("FAIL reprog_hold%0d: got %b want 0011", b, ipin_out); end
         shift_bits(new_w, b, b);
      end
      n_vec++; if (ipin_out !== 4'b0011) begin n_err++; $display("FAIL reprog_hold_end: got %b want 0011", ipin_out); end
      do_commit();
      n_vec++; if (ipin_out !== 4'b1110) begin n_err++; $display("FAIL reprog_new: got %b want 1110", ipin_out); end
      n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL reprog_done: got %b want 1", cfg_done); end
   endtask

   task automatic test_out_of_range();
      chany_top_in    = 30'h3FFFFFFF;
      chany_bottom_in = 30'h3FFFFFFF;
      #1;
      n_vec++; if (ipin_out !== 4'b1110) begin n_err++; $display("FAIL oor_ones: got %b want 1110", ipin_out); end
      chany_top_in    = 30'h0;
      #1;
      n_vec++; if (ipin_out !== 4'b0100) begin n_err++; $display("FAIL oor_bot: got %b want 0100", ipin_out); end
      chany_top_in    = 30'h3FFFFFFF;
      chany_bottom_in = 30'h0;
      #1;
      n_vec++; if (ipin_out !== 4'b1010) begin n_err++; $display("FAIL oor_top: got %b want 1010", ipin_out); end
   endtask

   task automatic test_reset_mid_shift();
      chany_top_in    = 30'h3FFFFFFF;
      chany_bottom_in = 30'h0;
      shift_bits(16'hFFFF, 15, 9);
      prog_reset = 1'b1;
      tick();
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", cfg_done); end
      n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", cfg_err); end
      n_vec++; if (ccff_tail !== 1'b0) begin n_err++; $display("FAIL mid_tail: got %b want 0", ccff_tail); end
      n_vec++; if (ipin_out !== 4'b0000) begin n_err++; $display("FAIL mid_ipin: got %b want 0000", ipin_out); end
      n_vec++; if (chany_bottom_out !== 30'h3FFFFFFF) begin n_err++; $display("FAIL mid_thru: got %h want 3fffffff", chany_bottom_out); end
      prog_reset = 1'b0;
      shift_bits(16'h0123, 15, 1);
      do_commit();
      n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL mid_cnt_restart: got %b want 1", cfg_err); end
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL mid_15_done: got %b want 0", cfg_done); end
      shift_bits(16'h0123, 0, 0);
      do_commit();
      n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL mid_reload_done: got %b want 1", cfg_done); end
      n_vec++; if (ipin_out !== 4'b0101) begin n_err++; $display("FAIL mid_reload_ipin: got %b want 0101", ipin_out); end
   endtask

   initial begin
      prog_reset      = 1'b1;
      ccff_head       = 1'b0;
      ccff_shift_en   = 1'b0;
      ccff_commit     = 1'b0;
      chany_bottom_in = 30'h0;
      chany_top_in    = 30'h0;
      test_reset();
      test_basic_load();
      test_illegal_commit();
      test_commit_with_shift();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
